// File: rtl/boot_load_ctrl_pkg.sv
// Shared CPU-side definitions for the boot loader: controller state encoding,
// store width codes and loader address arithmetic.
package boot_load_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_RUN   = 3'd3,
      ST_PASS  = 3'd4,
      ST_FAIL  = 3'd5
   } state_t;

   localparam logic [2:0] STORE_WORD = 3'b010;

   localparam int LEN_W   = 10;
   localparam int COUNT_W = 16;
   localparam int DATA_W  = 32;

   // Word index to byte address: words are 4 bytes, packed from the base upwards.
   function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] base,
                                                   input logic [LEN_W-1:0]  idx);
      return base + {{(DATA_W-LEN_W-2){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/boot_load_ctrl_if.sv
// Boot loader bus: session control, host word stream, loader memory write port
// and session status. The slave side is the controller, the master side its environment.
interface boot_load_ctrl_if;
   import boot_load_ctrl_pkg::*;

   logic               start;
   logic [LEN_W-1:0]   load_len;
   logic               host_valid;
   logic [DATA_W-1:0]  host_data;
   logic               host_ready;
   logic               correct_in;
   logic               cpu_reset;
   logic               mem_we;
   logic [DATA_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [2:0]         mem_store;
   logic               done;
   logic               pass;
   logic [COUNT_W-1:0] cycle_count;

   modport master (
      output start, load_len, host_valid, host_data, correct_in,
      input  host_ready, cpu_reset, mem_we, mem_addr, mem_wdata, mem_store,
      input  done, pass, cycle_count
   );

   modport slave (
      input  start, load_len, host_valid, host_data, correct_in,
      output host_ready, cpu_reset, mem_we, mem_addr, mem_wdata, mem_store,
      output done, pass, cycle_count
   );

endinterface

// File: rtl/boot_load_ctrl.sv
// Boot load/run controller: streams host words into data memory (write one cycle after
// acceptance), releases the CPU, then times the run until pass or timeout; host_ready only in LOAD.
module boot_load_ctrl
   import boot_load_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          MAX_WORDS = 64,
   parameter int          TIMEOUT   = 1000
) (
   input logic            clk,
   input logic            reset,
   boot_load_ctrl_if.slave bus
);

   localparam logic [COUNT_W-1:0] LAST_RUN_CYCLE = COUNT_W'(TIMEOUT - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX      = '1;

   state_t             state;
   logic [LEN_W-1:0]   word_idx;
   logic [LEN_W-1:0]   len_q;
   logic [COUNT_W-1:0] run_count;
   logic               wr_vld;
   logic [DATA_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_dat;

   logic accept;
   logic last_word;
   logic len_zero;
   logic len_too_big;
   logic session_idle;

   assign accept       = (state == ST_LOAD) && bus.host_valid;
   assign last_word    = (word_idx == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));
   assign len_zero     = (bus.load_len == '0);
   assign len_too_big  = 32'(bus.load_len) > 32'(MAX_WORDS);
   assign session_idle = (state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL);

   // Status outputs are pure decodes of the registered state.
   assign bus.host_ready  = (state == ST_LOAD);
   assign bus.cpu_reset   = (state != ST_RUN);
   assign bus.done        = (state == ST_PASS) || (state == ST_FAIL);
   assign bus.pass        = (state == ST_PASS);
   assign bus.cycle_count = run_count;

   assign bus.mem_we    = wr_vld;
   assign bus.mem_addr  = wr_addr;
   assign bus.mem_wdata = wr_dat;
   assign bus.mem_store = STORE_WORD;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         word_idx  <= '0;
         len_q     <= '0;
         run_count <= '0;
         wr_vld    <= 1'b0;
         wr_addr   <= '0;
         wr_dat    <= '0;
      end else begin
         // Loader write port: one registered write per accepted word, zeros otherwise.
         wr_vld  <= accept;
         wr_addr <= accept ? word_addr(ADDR_BASE, word_idx) : '0;
         wr_dat  <= accept ? bus.host_data : '0;

         case (state)
            ST_IDLE, ST_PASS, ST_FAIL: begin
               if (bus.start) begin
                  len_q     <= bus.load_len;
                  word_idx  <= '0;
                  run_count <= '0;
                  if (len_zero) begin
                     state <= ST_RUN;
                  end else if (len_too_big) begin
                     state <= ST_FAIL;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end

            ST_LOAD: begin
               if (accept) begin
                  word_idx <= word_idx + {{(LEN_W-1){1'b0}}, 1'b1};
                  if (last_word) begin
                     state <= ST_FLUSH;
                  end
               end
            end

            // The final word's write is on the port during this single cycle.
            ST_FLUSH: begin
               state <= ST_RUN;
            end

            ST_RUN: begin
               if (run_count != COUNT_MAX) begin
                  run_count <= run_count + {{(COUNT_W-1){1'b0}}, 1'b1};
               end
               // A pass seen on the last allowed cycle still counts as a pass.
               if (bus.correct_in) begin
                  state <= ST_PASS;
               end else if (run_count == LAST_RUN_CYCLE) begin
                  state <= ST_FAIL;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (session_idle && !bus.start) begin
            word_idx <= word_idx;
         end
      end
   end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Bench for boot_load_ctrl: table of whole sessions with fixed expectations, a reset-mid-load
// sequence, and random sessions checked cycle by cycle against a timeline computed from the rules.
module tb_boot_load_ctrl;
   import boot_load_ctrl_pkg::*;

   localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
   localparam int          MAX_WORDS = 64;
   localparam int          TIMEOUT   = 10;
   localparam int          NEVER     = 999;

   logic clk = 1'b0;
   logic reset;

   boot_load_ctrl_if bus();

   boot_load_ctrl #(
      .ADDR_BASE(ADDR_BASE),
      .MAX_WORDS(MAX_WORDS),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] d [0:MAX_WORDS-1];

   typedef struct {
      int len;
      int gap;
      int r;
      bit exp_pass;
      int exp_count;
      int exp_writes;
   } vec_t;

   vec_t vecs [0:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One session from a quiescent state. gap<0 gives random 0..3 idle cycles before
   // every word; otherwise the first word is offered at once and later words after
   // 'gap' idle cycles. r is the run cycle carrying correct_in (>= TIMEOUT: never).
   // Sample n is the state after the n-th edge following the start cycle.
   task automatic session(input int len, input int gap, input int r,
                          input bit exp_pass, input int exp_count, input int exp_writes);
      int  acc_at [0:MAX_WORDS-1];
      int  acc, last_acc, run0, run_len, end_n, writes, widx, nxt, g;
      bit  loads;

      loads = (len > 0) && (len <= MAX_WORDS);
      acc = 0;
      for (int k = 0; k < MAX_WORDS; k++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : ((k == 0) ? 0 : gap);
         acc = acc + g + 1;
         acc_at[k] = acc;
      end
      last_acc = loads ? acc_at[len-1] : 0;
      run0     = loads ? last_acc + 1 : 0;
      run_len  = (r < TIMEOUT) ? r + 1 : TIMEOUT;
      end_n    = (len > MAX_WORDS) ? 0 : run0 + run_len;
      writes   = 0;

      bus.start      = 1'b1;
      bus.load_len   = LEN_W'(len);
      bus.host_valid = 1'b0;
      bus.correct_in = 1'b0;

      for (int n = 0; n <= end_n; n++) begin
         step();
         widx = -1;
         for (int k = 0; k < len && k < MAX_WORDS; k++) begin
            if (loads && acc_at[k] == n) widx = k;
         end
         check("host_ready", 32'(bus.host_ready), 32'(loads && (n < last_acc)));
         check("mem_we", 32'(bus.mem_we), 32'(widx >= 0));
         check("mem_addr", bus.mem_addr, (widx >= 0) ? ADDR_BASE + 32'(4 * widx) : 32'h0);
         check("mem_wdata", bus.mem_wdata, (widx >= 0) ? d[widx] : 32'h0);
         check("mem_store", 32'(bus.mem_store), 32'h2);
         check("cpu_reset", 32'(bus.cpu_reset), 32'(!((n >= run0) && (n < end_n))));
         check("done", 32'(bus.done), 32'(n == end_n));
         check("pass", 32'(bus.pass), 32'((n == end_n) && exp_pass));
         check("cycle_count", 32'(bus.cycle_count), (n >= run0) ? 32'(n - run0) : 32'h0);
         if (bus.mem_we) writes++;

         if (n < end_n) begin
            // Starts and correct_in here land in LOAD/FLUSH/RUN or before RUN, and must be ignored.
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.load_len = LEN_W'($urandom_range(0, 3));
            nxt = -1;
            for (int k = 0; k < len && k < MAX_WORDS; k++) begin
               if (loads && acc_at[k] == n + 1) nxt = k;
            end
            bus.host_valid = (nxt >= 0);
            bus.host_data  = (nxt >= 0) ? d[nxt] : $urandom();
            bus.correct_in = (n >= run0) ? (n - run0 == r) : ($urandom_range(0, 1) == 1);
         end else begin
            bus.start      = 1'b0;
            bus.host_valid = 1'b0;
            bus.correct_in = 1'b0;
         end
      end

      check("writes", 32'(writes), 32'(exp_writes));
      check("final pass", 32'(bus.pass), 32'(exp_pass));
      check("final cycle_count", 32'(bus.cycle_count), 32'(exp_count));

      // Result must hold while idling in PASS/FAIL, with stray correct_in ignored.
      for (int i = 0; i < 2; i++) begin
         bus.correct_in = (i == 0);
         bus.host_valid = 1'b1;
         step();
         check("hold done", 32'(bus.done), 32'h1);
         check("hold pass", 32'(bus.pass), 32'(exp_pass));
         check("hold cycle_count", 32'(bus.cycle_count), 32'(exp_count));
         check("hold host_ready", 32'(bus.host_ready), 32'h0);
         check("hold mem_we", 32'(bus.mem_we), 32'h0);
         check("hold cpu_reset", 32'(bus.cpu_reset), 32'h1);
      end
      bus.correct_in = 1'b0;
      bus.host_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int len, r;
      bit ep;
      int ec, ew;

      //           len  gap  r      pass cnt  writes
      vecs[0] = '{3,    0,   5,     1,   6,   3};
      vecs[1] = '{2,    4,   3,     1,   4,   2};
      vecs[2] = '{0,    0,   NEVER, 0,   10,  0};
      vecs[3] = '{1,    0,   9,     1,   10,  1};
      vecs[4] = '{65,   0,   0,     0,   0,   0};
      vecs[5] = '{64,   0,   0,     1,   1,   64};
      vecs[6] = '{0,    0,   0,     1,   1,   0};
      vecs[7] = '{1023, 0,   0,     0,   0,   0};

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.load_len   = '0;
      bus.host_valid = 1'b0;
      bus.host_data  = '0;
      bus.correct_in = 1'b0;
      repeat (3) step();
      check("rst host_ready", 32'(bus.host_ready), 32'h0);
      check("rst cpu_reset", 32'(bus.cpu_reset), 32'h1);
      check("rst mem_we", 32'(bus.mem_we), 32'h0);
      check("rst mem_addr", bus.mem_addr, 32'h0);
      check("rst done", 32'(bus.done), 32'h0);
      check("rst pass", 32'(bus.pass), 32'h0);
      check("rst cycle_count", 32'(bus.cycle_count), 32'h0);
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         for (int k = 0; k < MAX_WORDS; k++) d[k] = 32'hA000_0000 + 32'(v * 256 + k);
         session(vecs[v].len, vecs[v].gap, vecs[v].r,
                 vecs[v].exp_pass, vecs[v].exp_count, vecs[v].exp_writes);
      end

      // Reset after one of four words: the second word's write must never appear.
      bus.start    = 1'b1;
      bus.load_len = LEN_W'(4);
      step();
      check("rl host_ready", 32'(bus.host_ready), 32'h1);
      bus.start      = 1'b0;
      bus.host_valid = 1'b1;
      bus.host_data  = 32'h1111_1111;
      step();
      check("rl first mem_we", 32'(bus.mem_we), 32'h1);
      check("rl first mem_addr", bus.mem_addr, ADDR_BASE);
      check("rl first mem_wdata", bus.mem_wdata, 32'h1111_1111);
      bus.host_data = 32'h2222_2222;
      reset         = 1'b1;
      step();
      check("rl mem_we", 32'(bus.mem_we), 32'h0);
      check("rl mem_wdata", bus.mem_wdata, 32'h0);
      check("rl host_ready", 32'(bus.host_ready), 32'h0);
      check("rl cpu_reset", 32'(bus.cpu_reset), 32'h1);
      check("rl done", 32'(bus.done), 32'h0);
      check("rl cycle_count", 32'(bus.cycle_count), 32'h0);
      reset          = 1'b0;
      bus.host_valid = 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) d[k] = 32'h5500_0000 + 32'(k);
      session(2, 0, 1, 1'b1, 2, 2);

      for (int s = 0; s < 24; s++) begin
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MAX_WORDS - 2, MAX_WORDS + 8))
                                           : int'($urandom_range(0, 12));
         r   = int'($urandom_range(0, TIMEOUT + 2));
         ep  = (len <= MAX_WORDS) && (r < TIMEOUT);
         ec  = (len > MAX_WORDS) ? 0 : ((r < TIMEOUT) ? r + 1 : TIMEOUT);
         ew  = (len <= MAX_WORDS) ? len : 0;
         for (int k = 0; k < MAX_WORDS; k++) d[k] = $urandom();
         session(len, -1, r, ep, ec, ew);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
